output_drain_ctrl: RTL and testbench
====================================

Name: output_drain_ctrl

Overview:
- Controller that sequences the output SRAM (DATA_WIDTH x DEPTH, sync write, sync read with 1-cycle latency).
- On a capture strobe it writes a full result vector from the systolic array into the SRAM, one word per cycle.
- It then reads each word back and streams it to the chip output pins as OUT_WIDTH-bit slices over a valid/ready handshake.
- It sits between the array result bus and the external interface and owns both SRAM ports exclusively.

Parameters:
- DATA_WIDTH, 16, width of one stored result; must be a multiple of OUT_WIDTH.
- DEPTH, 16, number of results per capture, equal to the SRAM depth.
- ADDR_WIDTH, $clog2(DEPTH), SRAM address width.
- OUT_WIDTH, 8, external output bus width; SLICES = DATA_WIDTH/OUT_WIDTH (default 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle capture request; ignored unless idle
- results_in  in  DEPTH*DATA_WIDTH  result vector; word k is bits [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high whenever state != IDLE
- done  out  1  registered one-cycle pulse after the last slice is accepted
- sram_we  out  1  SRAM write enable
- sram_waddr  out  ADDR_WIDTH  SRAM write address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_re  out  1  SRAM read enable
- sram_raddr  out  ADDR_WIDTH  SRAM read address
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_re
- out_data  out  OUT_WIDTH  output slice
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the slice when out_valid && out_ready

Behaviour:
Outputs and reset
- All outputs are decoded from registered state/counters; there is no combinational path from any input to any output.
- rst_n low (at any time, including mid-operation): state=IDLE, counters=0, word_buf=0, and all outputs 0.
- SRAM contents are not cleared by reset.

FSM states: IDLE, WRITE, RD_REQ, RD_WAIT, SEND.
- IDLE: start=1 -> WRITE with widx=0. start while busy is dropped, with no queuing.
- WRITE: sram_we=1, sram_waddr=widx, sram_wdata=results_in word widx.
  - widx increments each cycle; after widx=DEPTH-1 -> RD_REQ with ridx=0.
  - results_in must be held stable by upstream for the whole WRITE phase; it is not latched.
- RD_REQ: sram_re=1, sram_raddr=ridx -> RD_WAIT.
- RD_WAIT: word_buf <= sram_rdata, slice=0 -> SEND.
- SEND: out_valid=1, out_data = word_buf[slice*OUT_WIDTH +: OUT_WIDTH], least-significant slice first.
  - out_data is held stable while out_ready=0.
  - On a handshake with slice < SLICES-1: slice++.
  - On a handshake of the last slice with ridx < DEPTH-1: ridx++ -> RD_REQ.
  - On a handshake of the last slice with ridx = DEPTH-1: done <= 1 for one cycle -> IDLE.
- sram_we and sram_re are never high in the same cycle. Addresses never wrap beyond DEPTH-1.

Timing (defaults, out_ready tied high, start sampled at edge 0)
- WRITE occupies cycles 1..16.
- First out_valid in cycle 19.
- Each word costs 2 + SLICES cycles.
- Last handshake in cycle 80; done=1 and busy=0 in cycle 81.
- A start in cycle 81 is accepted.

Decomposition:
- Shared package mini_tpu_pkg holds:
  - the state enum encoding (IDLE=0, WRITE=1, RD_REQ=2, RD_WAIT=3, SEND=4, 3 bits);
  - localparam SLICES;
  - the default DATA_WIDTH/DEPTH/OUT_WIDTH constants, shared with output_sram.
- No sub-module; the FSM, counters and slice mux total roughly 150-200 lines.
- The top level instantiates this block beside output_sram.

Test Plan:
- Basic drain: results_in word k = 16'h1000+k, one start, out_ready=1 -> 32 slices in order 8'h00,8'h10,8'h01,8'h10,...,8'h0F,8'h10; done pulses in cycle 81; the SRAM model shows mem[k]=16'h1000+k.
- Backpressure: out_ready toggled 1-of-3 cycles randomly -> out_data stable while stalled, byte sequence identical to the basic case, no duplicated or dropped slices, done exactly once.
- Start while busy: a second start at cycles 5 and 40 with different results_in -> ignored; output matches the first capture; busy stays 1 throughout.
- Reset mid-drain: rst_n low during SEND of word 7 -> busy, out_valid, done, sram_we and sram_re go 0 asynchronously. A new start after release with word k = 16'hA5A5^k streams the new data from word 0.
- Back-to-back: start asserted in the same cycle done=1 -> accepted. The second capture's writes begin the next cycle, and its stream follows with correct data.
- Port exclusivity: an assertion checks sram_we && sram_re is never 1, addresses stay < DEPTH, and every sram_re is followed by a RD_WAIT capture.

Source files
------------

// File: rtl/mini_tpu_pkg.sv
// Shared constants for the mini TPU output path: state encoding and default
// geometry of the output SRAM and its drain controller.
package mini_tpu_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int SLICES         = DEF_DATA_WIDTH / DEF_OUT_WIDTH;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;

endpackage

// File: rtl/output_drain_ctrl_chk.sv
// Protocol checker for the drain controller's SRAM ports: exclusive port use,
// in-range addresses, and a read-wait capture after every read request.
module output_drain_ctrl_chk #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  busy,
    input logic                  sram_we,
    input logic [ADDR_WIDTH-1:0] sram_waddr,
    input logic                  sram_re,
    input logic [ADDR_WIDTH-1:0] sram_raddr,
    input logic                  out_valid
);

    function automatic bit in_range(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    a_port_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(sram_we && sram_re));

    a_waddr_range: assert property (@(posedge clk) disable iff (!rst_n)
        sram_we |-> in_range(sram_waddr));

    a_raddr_range: assert property (@(posedge clk) disable iff (!rst_n)
        sram_re |-> in_range(sram_raddr));

    a_rd_wait: assert property (@(posedge clk) disable iff (!rst_n)
        sram_re |=> (busy && !sram_re && !sram_we && !out_valid));

    a_rd_capture: assert property (@(posedge clk) disable iff (!rst_n)
        sram_re |-> ##2 out_valid);

endmodule

// File: rtl/output_drain_ctrl.sv
// Captures a systolic-array result vector into the output SRAM, then reads it
// back word by word and streams each word out as OUT_WIDTH-bit slices.
module output_drain_ctrl
    import mini_tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DEPTH*DATA_WIDTH-1:0] results_in,
    output logic                        busy,
    output logic                        done,
    output logic                        sram_we,
    output logic [ADDR_WIDTH-1:0]       sram_waddr,
    output logic [DATA_WIDTH-1:0]       sram_wdata,
    output logic                        sram_re,
    output logic [ADDR_WIDTH-1:0]       sram_raddr,
    input  logic [DATA_WIDTH-1:0]       sram_rdata,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int N_SLICES = DATA_WIDTH / OUT_WIDTH;
    localparam int SLICE_W  = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [SLICE_W-1:0]    LAST_SLICE = SLICE_W'(N_SLICES - 1);

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [ADDR_WIDTH-1:0] widx_r;
    logic [ADDR_WIDTH-1:0] ridx_r;
    logic [SLICE_W-1:0]    slice_r;
    logic [DATA_WIDTH-1:0] word_buf_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  done_r;
    logic                  handshake_s;
    logic                  last_slice_s;

    function automatic logic [DATA_WIDTH-1:0] word_at(
        input logic [DEPTH*DATA_WIDTH-1:0] vec,
        input int unsigned                 k
    );
        return vec[k*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign handshake_s  = (state_r == ST_SEND) && out_ready;
    assign last_slice_s = (slice_r == LAST_SLICE);

    // Next-state decode of the capture/drain sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_WRITE;
                else       state_nxt_s = ST_IDLE;
            end
            ST_WRITE: begin
                if (widx_r == LAST_IDX) state_nxt_s = ST_RD_REQ;
                else                    state_nxt_s = ST_WRITE;
            end
            ST_RD_REQ:  state_nxt_s = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt_s = ST_SEND;
            ST_SEND: begin
                if (handshake_s && last_slice_s) begin
                    if (ridx_r == LAST_IDX) state_nxt_s = ST_IDLE;
                    else                    state_nxt_s = ST_RD_REQ;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, index counters, write-data pipeline, read buffer and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            widx_r     <= '0;
            ridx_r     <= '0;
            slice_r    <= '0;
            word_buf_r <= '0;
            wdata_r    <= '0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Write data is staged one cycle ahead so sram_wdata
                    // comes straight from a flop rather than from results_in.
                    if (start) begin
                        widx_r  <= '0;
                        wdata_r <= word_at(results_in, 32'd0);
                    end
                end
                ST_WRITE: begin
                    if (widx_r == LAST_IDX) begin
                        widx_r  <= '0;
                        ridx_r  <= '0;
                        wdata_r <= '0;
                    end else begin
                        widx_r  <= widx_r + ADDR_WIDTH'(1);
                        wdata_r <= word_at(results_in, 32'(widx_r) + 32'd1);
                    end
                end
                ST_RD_REQ: begin
                    slice_r <= '0;
                end
                ST_RD_WAIT: begin
                    word_buf_r <= sram_rdata;
                    slice_r    <= '0;
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        if (!last_slice_s) begin
                            slice_r <= slice_r + SLICE_W'(1);
                        end else if (ridx_r != LAST_IDX) begin
                            slice_r <= '0;
                            ridx_r  <= ridx_r + ADDR_WIDTH'(1);
                        end else begin
                            slice_r <= '0;
                            ridx_r  <= '0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    widx_r  <= '0;
                    ridx_r  <= '0;
                    slice_r <= '0;
                end
            endcase
        end
    end

    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign sram_we    = (state_r == ST_WRITE);
    assign sram_waddr = sram_we ? widx_r : '0;
    assign sram_wdata = sram_we ? wdata_r : '0;
    assign sram_re    = (state_r == ST_RD_REQ);
    assign sram_raddr = sram_re ? ridx_r : '0;
    assign out_valid  = (state_r == ST_SEND);
    assign out_data   = out_valid ? word_buf_r[slice_r*OUT_WIDTH +: OUT_WIDTH] : '0;

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Self-checking bench for output_drain_ctrl: timing table for the basic drain,
// hand-written corner sequences, and a slice-queue scoreboard on every cycle.
module tb_output_drain_ctrl;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int AW = 4;
    localparam int OW = 8;
    localparam int VW = DP * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [VW-1:0] results_in;
    logic          busy;
    logic          done;
    logic          sram_we;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;
    logic          sram_re;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 1'b0;

    output_drain_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .results_in(results_in),
        .busy(busy), .done(done),
        .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    output_drain_ctrl_chk #(.DEPTH(DP), .ADDR_WIDTH(AW)) u_chk (
        .clk(clk), .rst_n(rst_n), .busy(busy),
        .sram_we(sram_we), .sram_waddr(sram_waddr),
        .sram_re(sram_re), .sram_raddr(sram_raddr), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: sync write, registered read, contents survive reset
    logic [DW-1:0] mem [DP];
    always @(posedge clk) begin
        if (sram_we) mem[sram_waddr] <= sram_wdata;
        if (sram_re) sram_rdata <= mem[sram_raddr];
    end

    // Scoreboard: the controller is idle exactly when no slices are owed
    logic [OW-1:0] exp_q [$];
    bit            done_due  = 1'b0;
    bit            prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    always @(negedge clk) begin
        bit was_empty;
        if (!rst_n) begin
            exp_q.delete();
            done_due   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            was_empty = (exp_q.size() == 0);
            total++;
            if (busy !== !was_empty) begin
                bad++;
                $display("FAIL sb_busy t=%0t: got %b want %b", $time, busy, !was_empty);
            end
            total++;
            if (done !== done_due) begin
                bad++;
                $display("FAIL sb_done t=%0t: got %b want %b", $time, done, done_due);
            end
            done_due = 1'b0;
            if (prev_stall) begin
                total++;
                if (!(out_valid === 1'b1 && out_data === prev_data)) begin
                    bad++;
                    $display("FAIL sb_stall t=%0t: got valid=%b data=%h want valid=1 data=%h",
                             $time, out_valid, out_data, prev_data);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                total++;
                if (was_empty) begin
                    bad++;
                    $display("FAIL sb_extra t=%0t: got slice %h want none", $time, out_data);
                end else begin
                    logic [OW-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL sb_slice t=%0t: got %h want %h", $time, out_data, e);
                    end
                    if (exp_q.size() == 0) done_due = 1'b1;
                end
            end
            if (start && was_empty) begin
                for (int k = 0; k < DP; k++)
                    for (int s = 0; s < DW / OW; s++)
                        exp_q.push_back(results_in[k*DW + s*OW +: OW]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 2) == 0);
        else            out_ready = 1'b1;
    endtask

    task automatic capture(input logic [VW-1:0] vec);
        results_in = vec;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_done: got no done pulse want one within %0d cycles", budget);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pat_add(input logic [DW-1:0] base);
        logic [VW-1:0] v;
        for (int k = 0; k < DP; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    function automatic logic [VW-1:0] pat_xor(input logic [DW-1:0] base);
        logic [VW-1:0] v;
        for (int k = 0; k < DP; k++) v[k*DW +: DW] = base ^ DW'(k);
        return v;
    endfunction

    function automatic logic [VW-1:0] pat_rand();
        logic [VW-1:0] v;
        for (int k = 0; k < DP; k++) v[k*DW +: DW] = DW'($urandom_range(0, 65535));
        return v;
    endfunction

    // {busy, done, we, waddr, wdata, re, raddr, valid, data}
    typedef logic [36:0] obs_t;
    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    function automatic obs_t obs();
        return {busy, done, sram_we, sram_waddr, sram_wdata, sram_re, sram_raddr, out_valid, out_data};
    endfunction

    function automatic vec_t mk(input int cyc, input logic b, input logic d, input logic we,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic re, input logic [AW-1:0] ra,
                                input logic v, input logic [OW-1:0] od);
        vec_t r;
        r.cyc = cyc;
        r.exp = {b, d, we, wa, wd, re, ra, v, od};
        return r;
    endfunction

    vec_t vecs [13];

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        results_in = '0;

        vecs[0]  = mk(1,  1'b1, 1'b0, 1'b1, 4'd0,  16'h1000, 1'b0, 4'd0, 1'b0, 8'h00);
        vecs[1]  = mk(2,  1'b1, 1'b0, 1'b1, 4'd1,  16'h1001, 1'b0, 4'd0, 1'b0, 8'h00);
        vecs[2]  = mk(16, 1'b1, 1'b0, 1'b1, 4'd15, 16'h100F, 1'b0, 4'd0, 1'b0, 8'h00);
        vecs[3]  = mk(17, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd0, 1'b0, 8'h00);
        vecs[4]  = mk(18, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 8'h00);
        vecs[5]  = mk(19, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 8'h00);
        vecs[6]  = mk(20, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 8'h10);
        vecs[7]  = mk(21, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd1, 1'b0, 8'h00);
        vecs[8]  = mk(23, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 8'h01);
        vecs[9]  = mk(79, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 8'h0F);
        vecs[10] = mk(80, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 8'h10);
        vecs[11] = mk(81, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 8'h00);
        vecs[12] = mk(82, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("reset_state", 64'(obs()), 64'd0);

        // Basic drain against the cycle table
        results_in = pat_add(16'h1000);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) begin
                tick();
                cyc++;
            end
            total++;
            if (obs() !== vecs[i].exp) begin
                bad++;
                $display("FAIL vec%0d cyc=%0d: got %h want %h", i, vecs[i].cyc, obs(), vecs[i].exp);
            end
        end
        for (int k = 0; k < DP; k++)
            check($sformatf("mem[%0d]", k), 64'(mem[k]), 64'(16'h1000 + DW'(k)));

        // Backpressure: same capture, consumer ready about one cycle in three
        rand_ready = 1'b1;
        capture(pat_add(16'h1000));
        wait_done(2000);
        rand_ready = 1'b0;
        tick();

        // Starts while busy are dropped, one with different data
        capture(pat_add(16'h2000));
        cyc = 1;
        while (cyc < 5) begin tick(); cyc++; end
        start = 1'b1;
        tick(); cyc++;
        start = 1'b0;
        while (cyc < 40) begin tick(); cyc++; end
        results_in = pat_xor(16'h7E7E);
        start = 1'b1;
        tick(); cyc++;
        start = 1'b0;
        wait_done(200);
        tick();

        // Reset in the middle of sending word 7
        capture(pat_add(16'h3000));
        cyc = 1;
        while (cyc < 47) begin tick(); cyc++; end
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outs", 64'({busy, out_valid, done, sram_we, sram_re}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        capture(pat_xor(16'hA5A5));
        wait_done(200);

        // Back-to-back: start in the same cycle as done
        results_in = pat_add(16'h4000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_we", 64'({sram_we, sram_waddr, sram_wdata}), 64'({1'b1, 4'd0, 16'h4000}));
        wait_done(200);
        tick();

        // Random captures with random backpressure and spurious starts
        rand_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bit seen;
            seen = 1'b0;
            capture(pat_rand());
            for (int i = 0; i < 2000 && !seen; i++) begin
                tick();
                start = 1'b0;
                if (done) seen = 1'b1;
                else if (i < 60 && $urandom_range(0, 15) == 0) start = 1'b1;
            end
            start = 1'b0;
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL rand_done%0d: got no done pulse want one", n);
            end
            tick();
        end
        rand_ready = 1'b0;

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
